// File: rtl/onehot_dec_pkg.sv
// Shared definitions for the one-hot decoder buffer: storage states, counter width
// and an index-to-one-hot decode function that encoder-side checkers can reuse.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    localparam int ERRCNT_W     = 16;
    localparam int MAX_OUT_SIZE = 256;
    localparam int DEC_W        = MAX_OUT_SIZE + 1;

    // Bit MAX_OUT_SIZE of the result is the out-of-range flag; bits [size-1:0] are the one-hot vector.
    function automatic logic [DEC_W-1:0] onehot_decode(input logic [31:0] idx, input int size);
        logic [DEC_W-1:0] dec;
        dec = '0;
        for (int k = 0; k < MAX_OUT_SIZE; k++) begin
            dec[k] = (idx == 32'(k)) && (k < size);
        end
        dec[MAX_OUT_SIZE] = (idx >= 32'(size));
        return dec;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready buffer with registered outputs and a registered
// in_ready that has no combinational path from out_ready.
module skid_buf2
    import onehot_dec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_t       r_state;
    buf_state_t       w_next_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_xfer;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_clr_main;
    logic             w_load_skid;
    logic             w_clr_skid;

    assign w_accept = in_valid & r_in_ready;
    assign w_xfer   = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_xfer) begin
                        w_next_state = ST_TWO;
                    end else if (!w_accept && w_xfer) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_TWO:   if (w_xfer) w_next_state = ST_ONE;
                default:  w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Data-path steering; emptied registers are cleared so out_data reads zero when idle.
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_clr_main       = 1'b0;
        w_load_skid      = 1'b0;
        w_clr_skid       = 1'b0;
        if (flush) begin
            w_clr_main = 1'b1;
            w_clr_skid = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: w_load_main_in = w_accept;
                ST_ONE: begin
                    if (w_accept && !w_xfer) begin
                        w_load_skid = 1'b1;
                    end else if (w_accept && w_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_xfer) begin
                        w_clr_main = 1'b1;
                    end
                end
                ST_TWO: begin
                    w_load_main_skid = w_xfer;
                    w_clr_skid       = w_xfer;
                end
                default: begin
                    w_clr_main = 1'b1;
                    w_clr_skid = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_clr_main) begin
                r_main <= '0;
            end else if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_clr_skid) begin
                r_skid <= '0;
            end else if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state != ST_TWO);
            r_out_valid <= (w_next_state != ST_EMPTY);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

endmodule

// File: rtl/onehot_dec_buf.sv
// Binary index to one-hot decoder behind a two-entry skid buffer.
// Define ONEHOT_DEC_ERRCNT_EN to add the saturating err_cnt output.
module onehot_dec_buf
    import onehot_dec_pkg::*;
#(
    parameter int OUT_SIZE = 8,
    parameter int IN_SIZE  = $clog2(OUT_SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_SIZE-1:0]  in_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out_onehot,
    output logic                out_err
`ifdef ONEHOT_DEC_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt
`endif
);

    if (OUT_SIZE < 2 || OUT_SIZE > MAX_OUT_SIZE) begin : g_bad_size
        $error("onehot_dec_buf: OUT_SIZE out of supported range");
    end

    logic [DEC_W-1:0]    w_dec;
    logic [OUT_SIZE-1:0] w_onehot;
    logic                w_err;
    logic [OUT_SIZE:0]   w_out_data;

    assign w_dec    = onehot_decode(32'(in_idx), OUT_SIZE);
    assign w_onehot = w_dec[OUT_SIZE-1:0];

    // Any decode bit at or above OUT_SIZE also marks the index as out of range.
    if (OUT_SIZE < MAX_OUT_SIZE) begin : g_err_fold
        assign w_err = w_dec[MAX_OUT_SIZE] | (|w_dec[MAX_OUT_SIZE-1:OUT_SIZE]);
    end else begin : g_err_direct
        assign w_err = w_dec[MAX_OUT_SIZE];
    end

    skid_buf2 #(
        .WIDTH(OUT_SIZE + 1)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({w_err, w_onehot}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_out_data)
    );

    assign out_onehot = w_out_data[OUT_SIZE-1:0];
    assign out_err    = w_out_data[OUT_SIZE];

`ifdef ONEHOT_DEC_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_cnt;

    // Counts accepted out-of-range indices; flush leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (in_valid && in_ready && !flush && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
